chess_move_controller: RTL and testbench
========================================

# chess_move_controller

Sequences all accesses to the board layout store: initialises the 64-square board after reset, moves the cursor on key pulses, validates and performs piece moves by read/modify/write of the store, and tracks whose turn it is. Sits between the debounced key inputs and the layout store. Its `MoveDone`/`Turn` outputs feed the game timers. Its `CursorIdx`/`SelectIdx` outputs feed the renderer's overlay.

## Interface
- `CHESS_SQUARES`, 64, number of squares; index = Y*8 + X, Y=0 is the top row.
- `SQUARE_WIDTH`, 8, bits per square: [3] colour (1 = black), [2:0] piece type (0 = empty), [7:4] written as 0.
- `CURSOR_INIT`, 26, cursor index after init (X=2, Y=3).
- `clock`  in  1  single clock, all logic on rising edge.
- `resetApp_n`  in  1  asynchronous, active-low reset.
- `KeyLeft`, `KeyRight`, `KeyUp`, `KeyDown`, `KeySelect`  in  1 each  single-cycle key pulses, already debounced.
- `BoardRdAddr`  out  6  read address; always equals `CursorIdx`.
- `BoardRdData`  in  8  store read data, valid one cycle after the address.
- `BoardWrEn`  out  1  write strobe.
- `BoardWrAddr`  out  6  write address.
- `BoardWrData`  out  8  write data.
- `CursorIdx`  out  6  current cursor square.
- `SelectIdx`  out  6  selected source square.
- `SelectValid`  out  1  high while a source square is selected.
- `Turn`  out  1  side to move; 0 = white, 1 = black.
- `MoveDone`  out  1  one-cycle pulse per completed move.
- `Ready`  out  1  high once initialisation is complete.

## Operation
- Reset values:
  - state INIT, init counter 0.
  - `CursorIdx`=`CURSOR_INIT`, `SelectIdx`=0.
  - `SelectValid`=0, `Turn`=0, `MoveDone`=0, `Ready`=0.
  - `BoardWrEn`=0, `BoardWrAddr`=0, `BoardWrData`=0.
- Piece codes: 1 pawn, 2 knight, 3 bishop, 4 rook, 5 queen, 6 king.
- INIT: write one square per cycle, addresses 0..63, in order.
  - Row 0: black back rank C A B D E B A C (hex).
  - Row 1: black pawns 09. Rows 2–5: 00. Row 6: white pawns 01.
  - Row 7: white back rank 04 02 03 05 06 03 02 04.
  - After address 63, go to IDLE and set `Ready`=1.
- Arrow keys (IDLE and ARMED only) step X or Y by one.
  - Clamp at board edges; no wrap-around.
  - Simultaneous keys: priority Select > Left > Right > Up > Down. One action per cycle.
- Keys arriving in any other state are dropped, not queued.
- IDLE, Select → RD_SRC → CHK_SRC.
  - CHK_SRC: if the square is non-empty and its colour equals `Turn`, latch the piece, set `SelectIdx`=`CursorIdx`, set `SelectValid`=1, go to ARMED.
  - Otherwise return to IDLE.
- ARMED, Select:
  - If `CursorIdx`==`SelectIdx`: clear `SelectValid` and go to IDLE (deselect).
  - Otherwise go RD_DST → CHK_DST.
  - CHK_DST: if the destination holds a piece of colour `Turn`, reject and stay ARMED with the selection kept.
  - Otherwise (empty square or capture): WR_DST writes the latched piece at `CursorIdx`, then WR_SRC writes 00 at `SelectIdx`, then DONE.
- DONE: toggle `Turn`, pulse `MoveDone`, clear `SelectValid`, go to IDLE.
- No further chess-legality checks are made (movement patterns, check, castling).

## Timing
- INIT lasts 64 cycles with `BoardWrEn` high throughout. `Ready` rises the cycle after the write to address 63.
- Cursor moves take effect in `CursorIdx` on the edge that samples the key.
- Selection: Select sampled at edge t → `SelectValid`=1 after edge t+3.
- Move: Select sampled at edge t.
  - `BoardWrEn` is high for the cycles after edges t+3 (destination write) and t+4 (source write).
  - `MoveDone`=1 and `Turn` toggled after edge t+5; `MoveDone` lasts exactly one cycle.
- `BoardWrEn` is registered and is never high outside INIT, WR_DST and WR_SRC.
- Reset asserted mid-move or mid-INIT: all outputs return to reset values immediately. INIT then rewrites the whole board, so no partial move survives.

## Structure
- Package `chess_pkg`:
  - piece-type and colour constants;
  - state enum (INIT, IDLE, RD_SRC, CHK_SRC, ARMED, RD_DST, CHK_DST, WR_DST, WR_SRC, DONE);
  - function `init_square(idx)` returning the start-position byte.
- Sub-module `chess_cursor`: clamped X/Y stepper with key priority and an enable input, producing `CursorIdx`. The FSM lives in the top.

## Test plan
- Reset release → 64 writes; idx 0=0C, 4=0E, 12=09, 52=01, 60=06; `Ready`=1 after 64 cycles; `CursorIdx`=26.
- From 26: seven KeyLeft → `CursorIdx`=24 (clamped at X=0); KeyLeft+KeyUp in the same cycle → only Left is applied.
- Move white pawn 52→36: Select on 52 → `SelectValid`=1, `SelectIdx`=52; Select on 36 → writes (36,01) then (52,00); `MoveDone` one cycle; `Turn`=1.
- Black to move, Select on white pawn 36 → stays IDLE, `SelectValid`=0; Select on 12, then Select on 13 (own pawn) → stays ARMED, no writes.
- Select then re-Select the same square → `SelectValid`=0, IDLE, `Turn` unchanged; keys during RD_SRC are ignored.
- Assert `resetApp_n` low during WR_DST → `BoardWrEn`=0 immediately; after release, full INIT, `Turn`=0.

Source files
------------

// File: rtl/chess_pkg.sv
// chess_pkg
// Shared definitions for the chess move controller slice:
//   - board geometry and square encoding constants
//   - piece-type and colour codes
//   - FSM state codes (plain localparams so older tools can consume them)
//   - init_square(): start-position byte for a given square index
package chess_pkg;

  localparam int CHESS_SQUARES = 64;
  localparam int SQUARE_WIDTH  = 8;
  localparam logic [5:0] CURSOR_INIT = 6'd26;

  localparam logic [2:0] PIECE_EMPTY  = 3'd0;
  localparam logic [2:0] PIECE_PAWN   = 3'd1;
  localparam logic [2:0] PIECE_KNIGHT = 3'd2;
  localparam logic [2:0] PIECE_BISHOP = 3'd3;
  localparam logic [2:0] PIECE_ROOK   = 3'd4;
  localparam logic [2:0] PIECE_QUEEN  = 3'd5;
  localparam logic [2:0] PIECE_KING   = 3'd6;

  localparam logic COLOUR_WHITE = 1'b0;
  localparam logic COLOUR_BLACK = 1'b1;

  typedef logic [3:0] state_t;
  localparam state_t ST_INIT    = 4'd0;
  localparam state_t ST_IDLE    = 4'd1;
  localparam state_t ST_RD_SRC  = 4'd2;
  localparam state_t ST_CHK_SRC = 4'd3;
  localparam state_t ST_ARMED   = 4'd4;
  localparam state_t ST_RD_DST  = 4'd5;
  localparam state_t ST_CHK_DST = 4'd6;
  localparam state_t ST_WR_DST  = 4'd7;
  localparam state_t ST_WR_SRC  = 4'd8;
  localparam state_t ST_DONE    = 4'd9;

  // Row 0 is black's back rank, row 7 white's; both use the same
  // rook-knight-bishop-queen-king-bishop-knight-rook column order.
  function automatic logic [7:0] init_square(input logic [5:0] idx);
    logic [2:0] row;
    logic [2:0] col;
    logic [2:0] backRank;
    logic [7:0] result;
    row = idx[5:3];
    col = idx[2:0];
    case (col)
      3'd0, 3'd7: backRank = PIECE_ROOK;
      3'd1, 3'd6: backRank = PIECE_KNIGHT;
      3'd2, 3'd5: backRank = PIECE_BISHOP;
      3'd3:       backRank = PIECE_QUEEN;
      default:    backRank = PIECE_KING;
    endcase
    case (row)
      3'd0:    result = {4'b0000, COLOUR_BLACK, backRank};
      3'd1:    result = {4'b0000, COLOUR_BLACK, PIECE_PAWN};
      3'd6:    result = {4'b0000, COLOUR_WHITE, PIECE_PAWN};
      3'd7:    result = {4'b0000, COLOUR_WHITE, backRank};
      default: result = 8'h00;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/chess_cursor.sv
// chess_cursor
// Clamped X/Y cursor stepper. One key action per cycle, priority
// Select > Left > Right > Up > Down; a Select pulse blocks arrow movement
// in the same cycle because the FSM consumes it instead.
// Ports:
//   clock, resetApp_n      clock and asynchronous active-low reset
//   enable                 arrow keys are honoured only while high
//   keySelect              used only for priority masking
//   keyLeft/Right/Up/Down  single-cycle key pulses
//   cursorIdx              current square, Y*8 + X
module chess_cursor
  import chess_pkg::*;
(
  input  logic       clock,
  input  logic       resetApp_n,
  input  logic       enable,
  input  logic       keySelect,
  input  logic       keyLeft,
  input  logic       keyRight,
  input  logic       keyUp,
  input  logic       keyDown,
  output logic [5:0] cursorIdx
);

  logic [2:0] posX;
  logic [2:0] posY;

  // Edge keys leave the position unchanged rather than wrapping.
  always_ff @(posedge clock or negedge resetApp_n) begin
    if (!resetApp_n) begin
      posX <= CURSOR_INIT[2:0];
      posY <= CURSOR_INIT[5:3];
    end else if (enable && !keySelect) begin
      if (keyLeft) begin
        if (posX != 3'd0) posX <= posX - 3'd1;
      end else if (keyRight) begin
        if (posX != 3'd7) posX <= posX + 3'd1;
      end else if (keyUp) begin
        if (posY != 3'd0) posY <= posY - 3'd1;
      end else if (keyDown) begin
        if (posY != 3'd7) posY <= posY + 3'd1;
      end
    end
  end

  assign cursorIdx = {posY, posX};

endmodule

// File: rtl/chess_move_controller.sv
// chess_move_controller
// Owns every access to the board layout store: writes the start position
// after reset, moves the cursor, validates and performs piece moves by
// read/modify/write, and tracks the side to move.
// Ports:
//   clock, resetApp_n                 clock and asynchronous active-low reset
//   KeyLeft/Right/Up/Down/Select      debounced single-cycle key pulses
//   BoardRdAddr/BoardRdData           store read port (data one cycle later)
//   BoardWrEn/BoardWrAddr/BoardWrData registered store write port
//   CursorIdx, SelectIdx, SelectValid overlay information for the renderer
//   Turn, MoveDone                    side to move and move-complete pulse
//   Ready                             start position fully written
module chess_move_controller
  import chess_pkg::*;
(
  input  logic                    clock,
  input  logic                    resetApp_n,
  input  logic                    KeyLeft,
  input  logic                    KeyRight,
  input  logic                    KeyUp,
  input  logic                    KeyDown,
  input  logic                    KeySelect,
  output logic [5:0]              BoardRdAddr,
  input  logic [SQUARE_WIDTH-1:0] BoardRdData,
  output logic                    BoardWrEn,
  output logic [5:0]              BoardWrAddr,
  output logic [SQUARE_WIDTH-1:0] BoardWrData,
  output logic [5:0]              CursorIdx,
  output logic [5:0]              SelectIdx,
  output logic                    SelectValid,
  output logic                    Turn,
  output logic                    MoveDone,
  output logic                    Ready
);

  state_t     state;
  logic [6:0] initCnt;
  logic [3:0] pieceLatch;
  logic       cursorEnable;
  logic       squareOwned;
  logic       unusedHighBits;

  // The upper nibble of a square carries no information.
  assign unusedHighBits = ^BoardRdData[7:4];

  // A square belongs to the side to move when it holds a piece of that colour.
  assign squareOwned = (BoardRdData[2:0] != PIECE_EMPTY) && (BoardRdData[3] == Turn);

  // Arrow keys are only meaningful while waiting for the player.
  assign cursorEnable = (state == ST_IDLE) || (state == ST_ARMED);

  chess_cursor uCursor (
    .clock      (clock),
    .resetApp_n (resetApp_n),
    .enable     (cursorEnable),
    .keySelect  (KeySelect),
    .keyLeft    (KeyLeft),
    .keyRight   (KeyRight),
    .keyUp      (KeyUp),
    .keyDown    (KeyDown),
    .cursorIdx  (CursorIdx)
  );

  // The store is always looking at the cursor square, so a read issued in
  // RD_SRC/RD_DST has its data ready in the following CHK state.
  assign BoardRdAddr = CursorIdx;

  // Main sequencer. Write strobe and MoveDone default low each cycle so they
  // can only be high for the single cycle after a writing/finishing state.
  always_ff @(posedge clock or negedge resetApp_n) begin
    if (!resetApp_n) begin
      state       <= ST_INIT;
      initCnt     <= 7'd0;
      pieceLatch  <= 4'd0;
      SelectIdx   <= 6'd0;
      SelectValid <= 1'b0;
      Turn        <= 1'b0;
      MoveDone    <= 1'b0;
      Ready       <= 1'b0;
      BoardWrEn   <= 1'b0;
      BoardWrAddr <= 6'd0;
      BoardWrData <= '0;
    end else begin
      BoardWrEn <= 1'b0;
      MoveDone  <= 1'b0;
      case (state)
        ST_INIT: begin
          if (initCnt == 7'(CHESS_SQUARES)) begin
            Ready <= 1'b1;
            state <= ST_IDLE;
          end else begin
            BoardWrEn   <= 1'b1;
            BoardWrAddr <= initCnt[5:0];
            BoardWrData <= init_square(initCnt[5:0]);
            initCnt     <= initCnt + 7'd1;
          end
        end
        ST_IDLE: begin
          if (KeySelect) state <= ST_RD_SRC;
        end
        ST_RD_SRC: state <= ST_CHK_SRC;
        ST_CHK_SRC: begin
          if (squareOwned) begin
            pieceLatch <= BoardRdData[3:0];
            SelectIdx  <= CursorIdx;
            state      <= ST_ARMED;
          end else begin
            state <= ST_IDLE;
          end
        end
        // SelectValid is raised on the first ARMED cycle, giving the
        // renderer a registered flag one edge after the source check.
        ST_ARMED: begin
          if (KeySelect && (CursorIdx == SelectIdx)) begin
            SelectValid <= 1'b0;
            state       <= ST_IDLE;
          end else begin
            SelectValid <= 1'b1;
            if (KeySelect) state <= ST_RD_DST;
          end
        end
        ST_RD_DST: state <= ST_CHK_DST;
        ST_CHK_DST: begin
          if (squareOwned) state <= ST_ARMED;
          else             state <= ST_WR_DST;
        end
        ST_WR_DST: begin
          BoardWrEn   <= 1'b1;
          BoardWrAddr <= CursorIdx;
          BoardWrData <= {4'b0000, pieceLatch};
          state       <= ST_WR_SRC;
        end
        ST_WR_SRC: begin
          BoardWrEn   <= 1'b1;
          BoardWrAddr <= SelectIdx;
          BoardWrData <= '0;
          state       <= ST_DONE;
        end
        ST_DONE: begin
          Turn        <= ~Turn;
          MoveDone    <= 1'b1;
          SelectValid <= 1'b0;
          state       <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_chess_move_controller.sv
// tb_chess_move_controller
// Directed bench for chess_move_controller with a behavioural 64x8 layout
// store (one-cycle read latency) and a log of every write strobe.
module tb_chess_move_controller;

  logic       clock = 1'b0;
  logic       resetApp_n;
  logic       KeyLeft, KeyRight, KeyUp, KeyDown, KeySelect;
  logic [5:0] BoardRdAddr;
  logic [7:0] BoardRdData;
  logic       BoardWrEn;
  logic [5:0] BoardWrAddr;
  logic [7:0] BoardWrData;
  logic [5:0] CursorIdx, SelectIdx;
  logic       SelectValid, Turn, MoveDone, Ready;

  logic [7:0]  mem [0:63];
  logic [13:0] wrLog [$];

  int testsRun    = 0;
  int testsFailed = 0;

  localparam logic [4:0] K_SEL   = 5'b10000;
  localparam logic [4:0] K_LEFT  = 5'b01000;
  localparam logic [4:0] K_RIGHT = 5'b00100;
  localparam logic [4:0] K_UP    = 5'b00010;
  localparam logic [4:0] K_DOWN  = 5'b00001;

  chess_move_controller dut (
    .clock       (clock),
    .resetApp_n  (resetApp_n),
    .KeyLeft     (KeyLeft),
    .KeyRight    (KeyRight),
    .KeyUp       (KeyUp),
    .KeyDown     (KeyDown),
    .KeySelect   (KeySelect),
    .BoardRdAddr (BoardRdAddr),
    .BoardRdData (BoardRdData),
    .BoardWrEn   (BoardWrEn),
    .BoardWrAddr (BoardWrAddr),
    .BoardWrData (BoardWrData),
    .CursorIdx   (CursorIdx),
    .SelectIdx   (SelectIdx),
    .SelectValid (SelectValid),
    .Turn        (Turn),
    .MoveDone    (MoveDone),
    .Ready       (Ready)
  );

  always #5 clock = ~clock;

  // Layout store model: synchronous read, write logged as {addr, data}.
  always @(posedge clock) begin
    BoardRdData <= mem[BoardRdAddr];
    if (BoardWrEn) begin
      mem[BoardWrAddr] <= BoardWrData;
      wrLog.push_back({BoardWrAddr, BoardWrData});
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic pressKeys(input logic [4:0] k);
    {KeySelect, KeyLeft, KeyRight, KeyUp, KeyDown} = k;
    tick();
    {KeySelect, KeyLeft, KeyRight, KeyUp, KeyDown} = 5'b00000;
  endtask

  // Releases reset and checks the full 64-write initialisation sequence.
  task automatic test_init();
    int highCnt = 0;
    int readyAt = 0;
    logic orderBad = 1'b0;
    wrLog.delete();
    resetApp_n = 1'b1;
    for (int n = 1; n <= 200; n++) begin
      tick();
      if (BoardWrEn === 1'b1) highCnt++;
      if (Ready === 1'b1) begin
        readyAt = n;
        break;
      end
    end
    testsRun++;
    if (readyAt != 65) begin
      testsFailed++;
      $display("[TB] FAIL init_ready_cycle: got %0d expected 65", readyAt);
    end
    testsRun++;
    if (highCnt != 64 || wrLog.size() != 64) begin
      testsFailed++;
      $display("[TB] FAIL init_write_count: strobe %0d log %0d expected 64", highCnt, wrLog.size());
    end
    for (int i = 0; i < wrLog.size() && i < 64; i++)
      if (wrLog[i][13:8] !== 6'(i)) orderBad = 1'b1;
    testsRun++;
    if (orderBad) begin
      testsFailed++;
      $display("[TB] FAIL init_write_order: addresses not 0..63 in order");
    end
    testsRun++;
    if ({mem[0], mem[4], mem[7], mem[12]} !== {8'h0C, 8'h0E, 8'h0C, 8'h09}) begin
      testsFailed++;
      $display("[TB] FAIL init_black_rows: got %h %h %h %h expected 0c 0e 0c 09",
               mem[0], mem[4], mem[7], mem[12]);
    end
    testsRun++;
    if ({mem[20], mem[36], mem[52], mem[60], mem[59]} !== {8'h00, 8'h00, 8'h01, 8'h06, 8'h05}) begin
      testsFailed++;
      $display("[TB] FAIL init_white_rows: got %h %h %h %h %h expected 00 00 01 06 05",
               mem[20], mem[36], mem[52], mem[60], mem[59]);
    end
    testsRun++;
    if (CursorIdx !== 6'd26 || Turn !== 1'b0 || BoardWrEn !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL init_end_state: cursor %0d turn %b wrEn %b expected 26 0 0",
               CursorIdx, Turn, BoardWrEn);
    end
  endtask

  task automatic test_reset();
    {KeySelect, KeyLeft, KeyRight, KeyUp, KeyDown} = 5'b00000;
    resetApp_n = 1'b0;
    tick();
    tick();
    testsRun++;
    if ({BoardWrEn, Ready, SelectValid, Turn, MoveDone, CursorIdx, SelectIdx, BoardWrAddr, BoardWrData}
        !== {5'b00000, 6'd26, 6'd0, 6'd0, 8'h00}) begin
      testsFailed++;
      $display("[TB] FAIL reset_values: wrEn %b ready %b selV %b turn %b done %b cur %0d sel %0d expected 0 0 0 0 0 26 0",
               BoardWrEn, Ready, SelectValid, Turn, MoveDone, CursorIdx, SelectIdx);
    end
    test_init();
  endtask

  task automatic test_cursor();
    pressKeys(K_LEFT);
    testsRun++;
    if (CursorIdx !== 6'd25) begin
      testsFailed++;
      $display("[TB] FAIL cursor_left_same_edge: got %0d expected 25", CursorIdx);
    end
    repeat (6) pressKeys(K_LEFT);
    testsRun++;
    if (CursorIdx !== 6'd24) begin
      testsFailed++;
      $display("[TB] FAIL cursor_clamp_left: got %0d expected 24", CursorIdx);
    end
    pressKeys(K_LEFT | K_UP);
    testsRun++;
    if (CursorIdx !== 6'd24) begin
      testsFailed++;
      $display("[TB] FAIL cursor_left_over_up: got %0d expected 24", CursorIdx);
    end
    pressKeys(K_RIGHT | K_DOWN);
    testsRun++;
    if (CursorIdx !== 6'd25) begin
      testsFailed++;
      $display("[TB] FAIL cursor_right_over_down: got %0d expected 25", CursorIdx);
    end
    repeat (3) pressKeys(K_RIGHT);
    repeat (3) pressKeys(K_DOWN);
    testsRun++;
    if (CursorIdx !== 6'd52) begin
      testsFailed++;
      $display("[TB] FAIL cursor_navigate: got %0d expected 52", CursorIdx);
    end
  endtask

  // White pawn 52 -> 36 with full cycle-level timing.
  task automatic test_move();
    pressKeys(K_SEL);
    tick();
    tick();
    testsRun++;
    if (SelectValid !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL select_not_early: got %b expected 0 after t+2", SelectValid);
    end
    tick();
    testsRun++;
    if (SelectValid !== 1'b1 || SelectIdx !== 6'd52) begin
      testsFailed++;
      $display("[TB] FAIL select_src: valid %b idx %0d expected 1 52", SelectValid, SelectIdx);
    end
    pressKeys(K_UP);
    pressKeys(K_UP);
    wrLog.delete();
    pressKeys(K_SEL);
    tick();
    tick();
    testsRun++;
    if (BoardWrEn !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL move_no_early_write: wrEn %b expected 0 after t+2", BoardWrEn);
    end
    tick();
    testsRun++;
    if ({BoardWrEn, BoardWrAddr, BoardWrData} !== {1'b1, 6'd36, 8'h01}) begin
      testsFailed++;
      $display("[TB] FAIL move_dst_write: wrEn %b addr %0d data %h expected 1 36 01",
               BoardWrEn, BoardWrAddr, BoardWrData);
    end
    tick();
    testsRun++;
    if ({BoardWrEn, BoardWrAddr, BoardWrData} !== {1'b1, 6'd52, 8'h00}) begin
      testsFailed++;
      $display("[TB] FAIL move_src_write: wrEn %b addr %0d data %h expected 1 52 00",
               BoardWrEn, BoardWrAddr, BoardWrData);
    end
    tick();
    testsRun++;
    if ({MoveDone, Turn, SelectValid, BoardWrEn} !== 4'b1100) begin
      testsFailed++;
      $display("[TB] FAIL move_done: done %b turn %b selV %b wrEn %b expected 1 1 0 0",
               MoveDone, Turn, SelectValid, BoardWrEn);
    end
    tick();
    testsRun++;
    if (MoveDone !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL move_done_width: got %b expected 0", MoveDone);
    end
    testsRun++;
    if (mem[36] !== 8'h01 || mem[52] !== 8'h00 || wrLog.size() != 2) begin
      testsFailed++;
      $display("[TB] FAIL move_board: sq36 %h sq52 %h writes %0d expected 01 00 2",
               mem[36], mem[52], wrLog.size());
    end
  endtask

  // Black to move: wrong-colour source, own-piece destination, deselect.
  task automatic test_reject();
    int extraWrites = 0;
    int donePulses = 0;
    pressKeys(K_SEL);
    repeat (3) tick();
    testsRun++;
    if (SelectValid !== 1'b0 || SelectIdx !== 6'd52) begin
      testsFailed++;
      $display("[TB] FAIL reject_wrong_colour: valid %b idx %0d expected 0 52", SelectValid, SelectIdx);
    end
    repeat (3) pressKeys(K_UP);
    pressKeys(K_SEL);
    repeat (3) tick();
    testsRun++;
    if (SelectValid !== 1'b1 || SelectIdx !== 6'd12) begin
      testsFailed++;
      $display("[TB] FAIL select_black_pawn: valid %b idx %0d expected 1 12", SelectValid, SelectIdx);
    end
    pressKeys(K_RIGHT);
    wrLog.delete();
    pressKeys(K_SEL);
    for (int i = 0; i < 5; i++) begin
      if (BoardWrEn === 1'b1) extraWrites++;
      if (MoveDone === 1'b1) donePulses++;
      tick();
    end
    testsRun++;
    if (extraWrites != 0 || wrLog.size() != 0 || donePulses != 0 || SelectValid !== 1'b1 || SelectIdx !== 6'd12) begin
      testsFailed++;
      $display("[TB] FAIL reject_own_dst: writes %0d done %0d valid %b idx %0d expected 0 0 1 12",
               wrLog.size(), donePulses, SelectValid, SelectIdx);
    end
    pressKeys(K_LEFT);
    pressKeys(K_SEL);
    tick();
    testsRun++;
    if (SelectValid !== 1'b0 || Turn !== 1'b1 || CursorIdx !== 6'd12) begin
      testsFailed++;
      $display("[TB] FAIL deselect: valid %b turn %b cur %0d expected 0 1 12", SelectValid, Turn, CursorIdx);
    end
  endtask

  task automatic test_back_to_back();
    pressKeys(K_SEL);
    pressKeys(K_RIGHT);
    testsRun++;
    if (CursorIdx !== 6'd12) begin
      testsFailed++;
      $display("[TB] FAIL key_drop_rd_src: cursor %0d expected 12", CursorIdx);
    end
    tick();
    tick();
    testsRun++;
    if (SelectValid !== 1'b1 || SelectIdx !== 6'd12) begin
      testsFailed++;
      $display("[TB] FAIL reselect_after_drop: valid %b idx %0d expected 1 12", SelectValid, SelectIdx);
    end
  endtask

  // Reset during the destination write, then a full re-initialisation.
  task automatic test_reset_mid_move();
    pressKeys(K_DOWN);
    pressKeys(K_SEL);
    repeat (3) tick();
    testsRun++;
    if ({BoardWrEn, BoardWrAddr, BoardWrData, Turn} !== {1'b1, 6'd20, 8'h09, 1'b1}) begin
      testsFailed++;
      $display("[TB] FAIL black_dst_write: wrEn %b addr %0d data %h turn %b expected 1 20 09 1",
               BoardWrEn, BoardWrAddr, BoardWrData, Turn);
    end
    resetApp_n = 1'b0;
    #1;
    testsRun++;
    if ({BoardWrEn, Ready, SelectValid, Turn, MoveDone, CursorIdx, SelectIdx, BoardWrAddr, BoardWrData}
        !== {5'b00000, 6'd26, 6'd0, 6'd0, 8'h00}) begin
      testsFailed++;
      $display("[TB] FAIL async_reset: wrEn %b ready %b selV %b turn %b done %b cur %0d sel %0d expected 0 0 0 0 0 26 0",
               BoardWrEn, Ready, SelectValid, Turn, MoveDone, CursorIdx, SelectIdx);
    end
    tick();
    tick();
    test_init();
  endtask

  initial begin
    resetApp_n = 1'b0;
    {KeySelect, KeyLeft, KeyRight, KeyUp, KeyDown} = 5'b00000;
    test_reset();
    test_cursor();
    test_move();
    test_reject();
    test_back_to_back();
    test_reset_mid_move();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
